// File: rtl/fl_alloc_ctrl.sv
// fl_alloc_ctrl: front-end sequencer for the Freelist.
// - Grants dispatch slots, strictly in order, onto free PR lanes.
// - Steps the Freelist through branch recovery and blocks allocation until it settles.
// - Holds retiring PRs in a small FIFO while the retire port is unavailable.

`ifndef SYS_PHYS_REG_ADDR_WIDTH
`define SYS_PHYS_REG_ADDR_WIDTH 6
`endif

module fl_alloc_ctrl #(
  parameter int W          = 3,
  parameter int PRW        = `SYS_PHYS_REG_ADDR_WIDTH,
  parameter int REC_CYCLES = 2,
  parameter int RQ_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     dis_req_mask,
  output logic [W*PRW-1:0] dis_pr_list,
  output logic [W-1:0]     dis_grant_mask,
  output logic             dis_stall,
  input  logic [W-1:0]     rt_en_mask,
  input  logic [W*PRW-1:0] rt_pr_list,
  output logic             rt_stall,
  input  logic             br_rec_req,
  output logic             rec_busy,
  input  logic [W-1:0]     fl_alloc_valid_mask,
  input  logic [W*PRW-1:0] fl_allocated_pr_list,
  output logic [W-1:0]     fl_dispatch_en_mask,
  output logic [W-1:0]     fl_retire_en_mask,
  output logic [W*PRW-1:0] fl_retired_pr_list,
  output logic             fch_rec_enable
);

  localparam int AW = $clog2(RQ_DEPTH);
  localparam int CW = $clog2(REC_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECOVER = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(RQ_DEPTH);
  localparam logic [AW:0]   W_C        = (AW+1)'(W);
  localparam logic [AW:0]   ONE_C      = (AW+1)'(1);
  localparam logic [CW-1:0] REC_LAST_C = CW'(REC_CYCLES - 1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PRW-1:0] mem_q [RQ_DEPTH];

  logic           idle_s, empty_s, bypass_s, ovf_s;
  logic [AW:0]    count_s, free_s, deq_n_s;
  logic [W-1:0]   enq_vld_s;
  logic [AW-1:0]  enq_idx_s [W];
  logic [AW:0]    rank_s [W];

  assign idle_s         = (state_q == ST_IDLE);
  assign count_s        = wr_ptr_q - rd_ptr_q;
  assign free_s         = DEPTH_C - count_s;
  assign empty_s        = (wr_ptr_q == rd_ptr_q);
  assign bypass_s       = rst && idle_s && empty_s;
  assign deq_n_s        = idle_s ? ((count_s < W_C) ? count_s : W_C) : '0;
  assign rec_busy       = !idle_s;
  assign fch_rec_enable = (state_q == ST_RECOVER);
  assign rt_stall       = (free_s < W_C);

  // In-order grant: the n-th requesting slot takes the n-th valid lane; the first shortfall stops all younger slots.
  always_comb begin
    logic [W-1:0]     used_v, grant_v;
    logic [W*PRW-1:0] pr_v;
    logic             stop_v, found_v;
    used_v  = '0;
    grant_v = '0;
    pr_v    = '0;
    stop_v  = 1'b0;
    found_v = 1'b0;
    for (int i = 0; i < W; i++) begin
      found_v = 1'b0;
      if (dis_req_mask[i] && !stop_v) begin
        for (int j = 0; j < W; j++) begin
          if (!found_v && fl_alloc_valid_mask[j] && !used_v[j]) begin
            found_v    = 1'b1;
            used_v[j]  = 1'b1;
            grant_v[i] = 1'b1;
            pr_v[i*PRW +: PRW] = fl_allocated_pr_list[j*PRW +: PRW];
          end else begin
            found_v = found_v;
          end
        end
        stop_v = !found_v;
      end else begin
        stop_v = stop_v;
      end
    end
    if (rst && idle_s) begin
      dis_grant_mask      = grant_v;
      dis_pr_list         = pr_v;
      fl_dispatch_en_mask = used_v;
    end else begin
      dis_grant_mask      = '0;
      dis_pr_list         = '0;
      fl_dispatch_en_mask = '0;
    end
    dis_stall = |(dis_req_mask & ~dis_grant_mask);
  end

  // Recovery sequencing: one strobe cycle, then REC_CYCLES of settling before allocation resumes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (br_rec_req) begin
          state_d = ST_RECOVER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        state_d = ST_DRAIN;
        cnt_d   = REC_LAST_C;
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Retire path: bypass when nothing is queued, otherwise enqueue in lane order and drain oldest-first in IDLE.
  always_comb begin
    logic [AW:0] rank_v, enq_v;
    rank_v             = '0;
    enq_v              = '0;
    ovf_s              = 1'b0;
    enq_vld_s          = '0;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    fl_retire_en_mask  = '0;
    fl_retired_pr_list = '0;
    for (int l = 0; l < W; l++) begin
      enq_idx_s[l] = '0;
      rank_s[l]    = rank_v;
      if (rt_en_mask[l]) begin
        rank_v = rank_v + ONE_C;
      end else begin
        rank_v = rank_v;
      end
    end
    if (!rst) begin
      wr_ptr_d = wr_ptr_q;
    end else if (bypass_s) begin
      for (int l = 0; l < W; l++) begin
        for (int o = 0; o < W; o++) begin
          if (rt_en_mask[l] && (rank_s[l] == (AW+1)'(o))) begin
            fl_retire_en_mask[o]              = 1'b1;
            fl_retired_pr_list[o*PRW +: PRW] = rt_pr_list[l*PRW +: PRW];
          end else begin
            ovf_s = ovf_s;
          end
        end
      end
    end else begin
      for (int l = 0; l < W; l++) begin
        if (rt_en_mask[l]) begin
          if (({1'b0, count_s} + {1'b0, rank_s[l]}) < {1'b0, DEPTH_C}) begin
            enq_vld_s[l] = 1'b1;
            enq_idx_s[l] = AW'(wr_ptr_q + rank_s[l]);
            enq_v        = enq_v + ONE_C;
          end else begin
            ovf_s = 1'b1;
          end
        end else begin
          ovf_s = ovf_s;
        end
      end
      wr_ptr_d = wr_ptr_q + enq_v;
      for (int o = 0; o < W; o++) begin
        if ((AW+1)'(o) < deq_n_s) begin
          fl_retire_en_mask[o]              = 1'b1;
          fl_retired_pr_list[o*PRW +: PRW] = mem_q[AW'(rd_ptr_q + (AW+1)'(o))];
        end else begin
          ovf_s = ovf_s;
        end
      end
      rd_ptr_d = rd_ptr_q + deq_n_s;
    end
  end

  // Recovery state and drain counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Retire FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Retire FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RQ_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int l = 0; l < W; l++) begin
        if (enq_vld_s[l]) begin
          mem_q[enq_idx_s[l]] <= rt_pr_list[l*PRW +: PRW];
        end
      end
    end
  end

`ifndef SYNTHESIS
  // A dropped retire means upstream ignored rt_stall; flag it loudly in simulation.
  always_ff @(posedge clk) begin
    if (rst && ovf_s) begin
      $error("fl_alloc_ctrl: retire FIFO overflow, PR dropped");
    end
  end
`endif

endmodule
